alu_arbiter: RTL and testbench

Shares the single 32-bit `alu` datapath between two independent requesters, each with valid/ready handshakes. The block is a registered front end:
- latches operands and control from the granted requester;
- drives the ALU for one execute cycle;
- captures result and flags;
- returns them on a per-requester response channel.

It sits between the ALU and the lab's control/test logic, and is the only driver of the ALU inputs.

---
 rtl/alu_arbiter.sv | 161 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one combinational ALU between two valid/ready requesters. The granted
// request's operands are registered onto the ALU inputs. The ALU gets one full
// cycle to settle. The result and flags are then captured and returned on the
// granted requester's response channel.
//
// Optional build macro: ALU_ARB_FIXED_PRIO_EN
//   undefined (default) : round-robin, the requester not served last wins a tie
//   defined             : requester 0 always wins a tie; last is still tracked
//
// Ports
//   clk, rst_n              clock, async active-low reset
//   req_valid/req_ready[1:0] per-requester request handshake
//   req_a*/req_b*/req_ctrl*  operands and ALU control per requester
//   rsp_valid/rsp_ready[1:0] per-requester response handshake
//   rsp_data, rsp_flags      captured result and {carry, ovf, zero}
//   alu_a, alu_b, alu_ctrl   registered ALU inputs
//   alu_out, alu_zero/ovf/carry  ALU result and flags
//   busy                     high outside IDLE
//   ops_done                 saturating count of completed responses
//
// state | meaning
// IDLE  | waiting for a request; req_ready is driven from arbitration
// EXEC  | ALU settling on registered operands
// RESP  | result held on rsp_* until the granted requester accepts it
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [WIDTH-1:0]  req_a0,
    input  logic [WIDTH-1:0]  req_a1,
    input  logic [WIDTH-1:0]  req_b0,
    input  logic [WIDTH-1:0]  req_b1,
    input  logic [CTRL_W-1:0] req_ctrl0,
    input  logic [CTRL_W-1:0] req_ctrl1,
    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ready,
    output logic [WIDTH-1:0]  rsp_data,
    output logic [2:0]        rsp_flags,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [WIDTH-1:0]  alu_out,
    input  logic              alu_zero,
    input  logic              alu_ovf,
    input  logic              alu_carry,
    output logic              busy,
    output logic [CNT_W-1:0]  ops_done
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state_q, state_d;
    logic              gnt_q, gnt_d;
    logic              last_q, last_d;
    logic              gnt_nxt;
    logic              accept;
    logic              rsp_done;

    logic [WIDTH-1:0]  alu_a_q, alu_b_q;
    logic [CTRL_W-1:0] alu_ctrl_q;
    logic [WIDTH-1:0]  rsp_data_q;
    logic [2:0]        rsp_flags_q;
    logic [CNT_W-1:0]  ops_q;

    // Arbitration. With a single valid request its index is simply req_valid[1].
    always_comb begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        gnt_nxt = ~req_valid[0];
`else
        if (&req_valid) gnt_nxt = ~last_q;
        else            gnt_nxt = req_valid[1];
`endif
    end

    assign accept   = (state_q == IDLE) && (|req_valid);
    assign rsp_done = (state_q == RESP) && rsp_ready[gnt_q];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    gnt_d   = gnt_nxt;
                    state_d = EXEC;
                end
            end
            EXEC: state_d = RESP;
            RESP: begin
                if (rsp_done) begin
                    last_d  = gnt_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        busy      = (state_q != IDLE);
        if (state_q == IDLE) req_ready[gnt_nxt] = req_valid[gnt_nxt];
        if (state_q == RESP) rsp_valid[gnt_q]   = 1'b1;
    end

    // Datapath registers; the ALU inputs hold whenever no request is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_ctrl_q  <= '0;
            rsp_data_q  <= '0;
            rsp_flags_q <= '0;
            ops_q       <= '0;
        end else begin
            if (accept) begin
                alu_a_q    <= gnt_nxt ? req_a1    : req_a0;
                alu_b_q    <= gnt_nxt ? req_b1    : req_b0;
                alu_ctrl_q <= gnt_nxt ? req_ctrl1 : req_ctrl0;
            end
            if (state_q == EXEC) begin
                rsp_data_q  <= alu_out;
                rsp_flags_q <= {alu_carry, alu_ovf, alu_zero};
            end
            if (rsp_done && (ops_q != '1)) ops_q <= ops_q + 1'b1;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_ctrl  = alu_ctrl_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_flags = rsp_flags_q;
    assign ops_done  = ops_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for alu_arbiter. Two instances share all stimulus: the default
// configuration and one with a 4-bit operation counter for saturation.
// The ALU is modelled behaviourally here and feeds each instance.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid, rsp_ready;
    logic [31:0] a0, a1, b0, b1;
    logic [3:0]  c0, c1;

    logic [1:0]  req_ready, rsp_valid, req_ready_s, rsp_valid_s;
    logic [31:0] rsp_data, alu_a, alu_b, alu_out;
    logic [31:0] rsp_data_s, alu_a_s, alu_b_s, alu_out_s;
    logic [2:0]  rsp_flags, rsp_flags_s;
    logic [3:0]  alu_ctrl, alu_ctrl_s;
    logic        alu_zero, alu_ovf, alu_carry, busy;
    logic        alu_zero_s, alu_ovf_s, alu_carry_s, busy_s;
    logic [15:0] ops_done;
    logic [3:0]  ops_done_s;

    int checks   = 0;
    int failures = 0;
    int exp_cnt  = 0;
    logic last_m = 1'b1;

    always #5 clk = ~clk;

    // Behavioural ALU: 0 and, 1 or, 2 add, 6 sub, else xor. Returns {carry, ovf, zero, result}.
    function automatic logic [34:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        logic [32:0] s;
        logic [31:0] r;
        logic        cy, ov;
        cy = 1'b0;
        ov = 1'b0;
        s  = '0;
        case (c)
            4'd0: r = a & b;
            4'd1: r = a | b;
            4'd2: begin
                s  = {1'b0, a} + {1'b0, b};
                r  = s[31:0];
                cy = s[32];
                ov = (a[31] == b[31]) && (r[31] != a[31]);
            end
            4'd6: begin
                s  = {1'b0, a} - {1'b0, b};
                r  = s[31:0];
                cy = s[32];
                ov = (a[31] != b[31]) && (r[31] != a[31]);
            end
            default: r = a ^ b;
        endcase
        return {cy, ov, (r == 32'd0), r};
    endfunction

    assign {alu_carry, alu_ovf, alu_zero, alu_out}         = alu_ref(alu_a, alu_b, alu_ctrl);
    assign {alu_carry_s, alu_ovf_s, alu_zero_s, alu_out_s} = alu_ref(alu_a_s, alu_b_s, alu_ctrl_s);

    alu_arbiter dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a0(a0), .req_a1(a1), .req_b0(b0), .req_b1(b1),
        .req_ctrl0(c0), .req_ctrl1(c1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_flags(rsp_flags),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_out(alu_out),
        .alu_zero(alu_zero), .alu_ovf(alu_ovf), .alu_carry(alu_carry),
        .busy(busy), .ops_done(ops_done)
    );

    alu_arbiter #(.CNT_W(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_s),
        .req_a0(a0), .req_a1(a1), .req_b0(b0), .req_b1(b1),
        .req_ctrl0(c0), .req_ctrl1(c1),
        .rsp_valid(rsp_valid_s), .rsp_ready(rsp_ready), .rsp_data(rsp_data_s), .rsp_flags(rsp_flags_s),
        .alu_a(alu_a_s), .alu_b(alu_b_s), .alu_ctrl(alu_ctrl_s), .alu_out(alu_out_s),
        .alu_zero(alu_zero_s), .alu_ovf(alu_ovf_s), .alu_carry(alu_carry_s),
        .busy(busy_s), .ops_done(ops_done_s)
    );

    typedef struct {
        logic [1:0]  vld;
        logic [31:0] a0, b0, a1, b1;
        logic [3:0]  c0, c1;
        logic        g;
        logic [31:0] d;
        logic [2:0]  f;
        int          stall;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // One complete transaction from the IDLE cycle to the response handshake.
    task automatic serve(input logic [1:0] vld, input logic g, input logic [31:0] ed,
                         input logic [2:0] ef, input int stall);
        logic [1:0] gm;
        gm = g ? 2'b10 : 2'b01;
        req_valid = vld;
        #1;
        chk("req_ready_idle", {30'd0, req_ready}, {30'd0, gm});
        chk("req_ready_idle_s", {30'd0, req_ready_s}, {30'd0, gm});
        chk("busy_idle", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        req_valid = vld & ~gm;
        chk("busy_exec", {31'd0, busy}, 32'd1);
        chk("rsp_valid_exec", {30'd0, rsp_valid}, 32'd0);
        chk("req_ready_exec", {30'd0, req_ready}, 32'd0);
        chk("alu_a", alu_a, g ? a1 : a0);
        chk("alu_b", alu_b, g ? b1 : b0);
        chk("alu_ctrl", {28'd0, alu_ctrl}, {28'd0, (g ? c1 : c0)});
        @(posedge clk); #1;
        for (int i = 0; i < stall; i++) begin
            rsp_ready = ~gm;
            #1;
            chk("rsp_valid_stall", {30'd0, rsp_valid}, {30'd0, gm});
            chk("rsp_data_stall", rsp_data, ed);
            chk("rsp_flags_stall", {29'd0, rsp_flags}, {29'd0, ef});
            chk("req_ready_stall", {30'd0, req_ready}, 32'd0);
            chk("busy_stall", {31'd0, busy}, 32'd1);
            @(posedge clk); #1;
        end
        rsp_ready = gm;
        #1;
        chk("rsp_valid", {30'd0, rsp_valid}, {30'd0, gm});
        chk("rsp_valid_s", {30'd0, rsp_valid_s}, {30'd0, gm});
        chk("rsp_data", rsp_data, ed);
        chk("rsp_flags", {29'd0, rsp_flags}, {29'd0, ef});
        @(posedge clk); #1;
        rsp_ready = 2'b00;
        if (exp_cnt < 65535) exp_cnt++;
        last_m = g;
        chk("rsp_valid_done", {30'd0, rsp_valid}, 32'd0);
        chk("busy_done", {31'd0, busy}, 32'd0);
        chk("ops_done", {16'd0, ops_done}, exp_cnt);
        chk("ops_done_sat", {28'd0, ops_done_s}, (exp_cnt > 15) ? 32'd15 : exp_cnt);
    endtask

    task automatic load(input vec_t v);
        a0 = v.a0; b0 = v.b0; c0 = v.c0;
        a1 = v.a1; b1 = v.b1; c1 = v.c1;
    endtask

    initial begin
        logic [3:0]  ctrls[4];
        logic [1:0]  vld;
        logic        g;
        logic [34:0] r;

        ctrls[0] = 4'd0; ctrls[1] = 4'd1; ctrls[2] = 4'd2; ctrls[3] = 4'd6;

        // Contention right after reset, with back-pressure on the first response.
        vecs[0] = '{2'b11, 32'd1, 32'd4, 32'd5, 32'd8, 4'd2, 4'd2, 1'b0, 32'd5,  3'b000, 5};
        vecs[1] = '{2'b10, 32'd1, 32'd4, 32'd5, 32'd8, 4'd2, 4'd2, 1'b1, 32'd13, 3'b000, 0};
        vecs[2] = '{2'b01, 32'd1, 32'd2, 32'd0, 32'd0, 4'd2, 4'd2, 1'b0, 32'd3,  3'b000, 1};
`ifdef ALU_ARB_FIXED_PRIO_EN
        vecs[3] = '{2'b11, 32'd1, 32'd4, 32'd5, 32'd8, 4'd2, 4'd2, 1'b0, 32'd5,  3'b000, 0};
        vecs[4] = '{2'b10, 32'd1, 32'd4, 32'd5, 32'd8, 4'd2, 4'd2, 1'b1, 32'd13, 3'b000, 0};
`else
        vecs[3] = '{2'b11, 32'd1, 32'd4, 32'd5, 32'd8, 4'd2, 4'd2, 1'b1, 32'd13, 3'b000, 0};
        vecs[4] = '{2'b01, 32'd1, 32'd4, 32'd5, 32'd8, 4'd2, 4'd2, 1'b0, 32'd5,  3'b000, 0};
`endif
        vecs[5] = '{2'b01, 32'h7FFF_FFFF, 32'd1, 32'd0, 32'd0, 4'd2, 4'd2, 1'b0, 32'h8000_0000, 3'b010, 0};
        vecs[6] = '{2'b01, 32'd0, 32'd0, 32'd0, 32'd0, 4'd2, 4'd2, 1'b0, 32'd0, 3'b001, 0};
        vecs[7] = '{2'b10, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd1, 4'd2, 4'd2, 1'b1, 32'd0, 3'b101, 2};
        vecs[8] = '{2'b10, 32'd0, 32'd0, 32'h0000_F0F0, 32'h0000_FF00, 4'd2, 4'd0, 1'b1, 32'h0000_F000, 3'b000, 0};

        rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00;
        a0 = '0; a1 = '0; b0 = '0; b1 = '0; c0 = '0; c1 = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_flags", {29'd0, rsp_flags}, 32'd0);
        chk("rst_ops_done", {16'd0, ops_done}, 32'd0);

        for (int i = 0; i < 9; i++) begin
            load(vecs[i]);
            serve(vecs[i].vld, vecs[i].g, vecs[i].d, vecs[i].f, vecs[i].stall);
        end

        // Reset during EXEC discards the operation.
        req_valid = 2'b00;
        a0 = 32'd3; b0 = 32'd4; c0 = 4'd2;
        @(posedge clk); #1;
        req_valid = 2'b01;
        @(posedge clk); #1;
        req_valid = 2'b00;
        chk("midop_busy_pre", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midop_busy", {31'd0, busy}, 32'd0);
        chk("midop_alu_a", alu_a, 32'd0);
        chk("midop_alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
        chk("midop_rsp_data", rsp_data, 32'd0);
        chk("midop_ops_done", {16'd0, ops_done}, 32'd0);
        chk("midop_ops_done_s", {28'd0, ops_done_s}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_cnt = 0;
        last_m  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("midop_no_rsp", {30'd0, rsp_valid}, 32'd0);
            chk("midop_cnt", {16'd0, ops_done}, 32'd0);
        end
        serve(2'b01, 1'b0, 32'd7, 3'b000, 0);

        // Random traffic against the arbitration rule and the ALU model.
        for (int n = 0; n < 30; n++) begin
            req_valid = 2'b00;
            vld = 2'($urandom_range(1, 3));
            a0 = $urandom; b0 = $urandom; c0 = ctrls[$urandom_range(0, 3)];
            a1 = $urandom; b1 = $urandom; c1 = ctrls[$urandom_range(0, 3)];
`ifdef ALU_ARB_FIXED_PRIO_EN
            g = ~vld[0];
`else
            g = (vld == 2'b11) ? ~last_m : vld[1];
`endif
            r = g ? alu_ref(a1, b1, c1) : alu_ref(a0, b0, c0);
            serve(vld, g, r[31:0], r[34:32], int'($urandom_range(0, 3)));
        end
        chk("sat_final", {28'd0, ops_done_s}, 32'd15);
        chk("cnt_final", {16'd0, ops_done}, 32'd31);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
